// File: rtl/bcd_timer_down_mm_ss.sv
// MM:SS BCD countdown timer with preset load, start/stop control and expiry.
// Flags are registered from the next-state value so they never glitch.
module bcd_timer_down_mm_ss #(
  parameter int unsigned MIN_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] pre_min_tens,
  input  logic [3:0] pre_min_ones,
  input  logic [3:0] pre_sec_tens,
  input  logic [3:0] pre_sec_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       load_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

  localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_mt, r_mo, r_st, r_so;
  logic [3:0] w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
  logic [3:0] w_mt_dec, w_mo_dec, w_st_dec, w_so_dec;
  logic       r_running, r_expired, r_done, r_load_err;
  logic       w_done_nxt, w_load_err_nxt;
  logic       w_load_ok, w_zero, w_at_one;
  logic       w_b_so, w_b_st, w_b_mo;

  assign w_load_ok = (pre_min_tens <= MT_MAX) && (pre_min_ones <= 4'd9) &&
                     (pre_sec_tens <= 4'd5)   && (pre_sec_ones <= 4'd9);
  assign w_zero    = ({r_mt, r_mo, r_st, r_so} == 16'h0000);
  assign w_at_one  = ({r_mt, r_mo, r_st, r_so} == 16'h0001);

  // Borrow ripples from seconds-ones up to minutes-tens.
  assign w_b_so   = (r_so == 4'd0);
  assign w_b_st   = w_b_so && (r_st == 4'd0);
  assign w_b_mo   = w_b_st && (r_mo == 4'd0);
  assign w_so_dec = w_b_so ? 4'd9 : r_so - 4'd1;
  assign w_st_dec = !w_b_so ? r_st : ((r_st == 4'd0) ? 4'd5 : r_st - 4'd1);
  assign w_mo_dec = !w_b_st ? r_mo : ((r_mo == 4'd0) ? 4'd9 : r_mo - 4'd1);
  assign w_mt_dec = !w_b_mo ? r_mt : r_mt - 4'd1;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_state_nxt    = r_state;
    w_mt_nxt       = r_mt;
    w_mo_nxt       = r_mo;
    w_st_nxt       = r_st;
    w_so_nxt       = r_so;
    w_done_nxt     = 1'b0;
    w_load_err_nxt = 1'b0;
    case (r_state)
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_PAUSE;
        end else if (tick) begin
          {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} = {w_mt_dec, w_mo_dec, w_st_dec, w_so_dec};
          if (w_at_one) begin
            w_state_nxt = S_EXPIRED;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        if (load) begin
          if (w_load_ok) begin
            {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} =
              {pre_min_tens, pre_min_ones, pre_sec_tens, pre_sec_ones};
            w_state_nxt = S_IDLE;
          end else begin
            w_load_err_nxt = 1'b1;
          end
        end else if (start && (r_state != S_EXPIRED) && !w_zero) begin
          w_state_nxt = S_RUN;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mt       <= 4'd0;
      r_mo       <= 4'd0;
      r_st       <= 4'd0;
      r_so       <= 4'd0;
      r_running  <= 1'b0;
      r_expired  <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mt       <= w_mt_nxt;
      r_mo       <= w_mo_nxt;
      r_st       <= w_st_nxt;
      r_so       <= w_so_nxt;
      r_running  <= (w_state_nxt == S_RUN);
      r_expired  <= (w_state_nxt == S_EXPIRED);
      r_done     <= w_done_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign min_tens = r_mt;
  assign min_ones = r_mo;
  assign sec_tens = r_st;
  assign sec_ones = r_so;
  assign running  = r_running;
  assign expired  = r_expired;
  assign done     = r_done;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_timer_down_mm_ss.sv
// Directed bench for bcd_timer_down_mm_ss: loads, borrows, expiry, pause,
// load rejection and asynchronous reset, with hand-computed expectations.
module tb_bcd_timer_down_mm_ss;

  logic       clk = 1'b0;
  logic       rst, tick, load, start, stop;
  logic [3:0] pre_min_tens, pre_min_ones, pre_sec_tens, pre_sec_ones;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, expired, done, load_err;
  logic [15:0] count;
  logic [3:0]  flags;

  int vectors    = 0;
  int miscompares = 0;

  assign count = {min_tens, min_ones, sec_tens, sec_ones};
  assign flags = {running, expired, done, load_err};

  always #5 clk = ~clk;

  bcd_timer_down_mm_ss #(.MIN_TENS_MAX(5)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .start(start), .stop(stop),
    .pre_min_tens(pre_min_tens), .pre_min_ones(pre_min_ones),
    .pre_sec_tens(pre_sec_tens), .pre_sec_ones(pre_sec_ones),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .expired(expired), .done(done), .load_err(load_err)
  );

  // Advance one clock; outputs are then sampled and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    {pre_min_tens, pre_min_ones, pre_sec_tens, pre_sec_ones} = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1; step(); tick = 1'b0;
  endtask

  // flags are {running, expired, done, load_err}
  task automatic expect_state(input string name, input logic [15:0] exp_cnt, input logic [3:0] exp_flags);
    vectors++;
    if (count !== exp_cnt) begin
      miscompares++;
      $display("FAIL %s count: got %h want %h", name, count, exp_cnt);
    end
    vectors++;
    if (flags !== exp_flags) begin
      miscompares++;
      $display("FAIL %s flags(run,exp,done,err): got %b want %b", name, flags, exp_flags);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {tick, load, start, stop} = '0;
    {pre_min_tens, pre_min_ones, pre_sec_tens, pre_sec_ones} = '0;
    #3;
    expect_state("reset_async", 16'h0000, 4'b0000);
    step(); step();
    rst = 1'b0;
    step();
    expect_state("reset_release", 16'h0000, 4'b0000);
  endtask

  task automatic test_basic();
    do_load(16'h0100);
    expect_state("load_0100", 16'h0100, 4'b0000);
    pulse_tick();
    expect_state("tick_in_idle", 16'h0100, 4'b0000);
    pulse_start();
    expect_state("start_0100", 16'h0100, 4'b1000);
    pulse_tick();
    expect_state("tick_0059", 16'h0059, 4'b1000);
  endtask

  task automatic test_borrow();
    do_load(16'h0200);
    expect_state("load_in_run_ignored", 16'h0059, 4'b1000);
    do_load(16'h0070);
    expect_state("bad_load_in_run_no_err", 16'h0059, 4'b1000);
    pulse_stop();
    expect_state("stop_pause", 16'h0059, 4'b0000);
    do_load(16'h1000);
    expect_state("load_1000", 16'h1000, 4'b0000);
    pulse_start();
    pulse_tick();
    expect_state("borrow_0959", 16'h0959, 4'b1000);
    tick = 1'b1;
    step(); step(); step();
    tick = 1'b0;
    expect_state("held_tick_x3", 16'h0956, 4'b1000);
  endtask

  task automatic test_expire();
    pulse_stop();
    do_load(16'h0002);
    pulse_start();
    pulse_tick();
    expect_state("expire_0001", 16'h0001, 4'b1000);
    pulse_tick();
    expect_state("expire_done", 16'h0000, 4'b0110);
    step();
    expect_state("done_one_cycle", 16'h0000, 4'b0100);
    tick = 1'b1; start = 1'b1;
    step(); step();
    tick = 1'b0; start = 1'b0;
    expect_state("expired_holds", 16'h0000, 4'b0100);
    pulse_stop();
    expect_state("stop_in_expired", 16'h0000, 4'b0100);
  endtask

  task automatic test_pause();
    do_load(16'h0330);
    expect_state("load_clears_expired", 16'h0330, 4'b0000);
    pulse_start();
    stop = 1'b1; tick = 1'b1;
    step();
    stop = 1'b0; tick = 1'b0;
    expect_state("stop_beats_tick", 16'h0330, 4'b0000);
    pulse_tick();
    expect_state("tick_in_pause", 16'h0330, 4'b0000);
    pulse_start();
    pulse_tick();
    expect_state("resume_0329", 16'h0329, 4'b1000);
  endtask

  task automatic test_load_err();
    pulse_stop();
    do_load(16'h0360);
    expect_state("bad_sec_tens", 16'h0329, 4'b0001);
    step();
    expect_state("load_err_one_cycle", 16'h0329, 4'b0000);
    do_load(16'h6000);
    expect_state("bad_min_tens", 16'h0329, 4'b0001);
    do_load(16'h001A);
    expect_state("bad_sec_ones", 16'h0329, 4'b0001);
    do_load(16'h5959);
    expect_state("load_max", 16'h5959, 4'b0000);
    do_load(16'h0000);
    expect_state("load_0000", 16'h0000, 4'b0000);
    pulse_start();
    expect_state("start_at_zero", 16'h0000, 4'b0000);
  endtask

  task automatic test_async_reset();
    do_load(16'h0518);
    pulse_start();
    pulse_tick();
    expect_state("run_0517", 16'h0517, 4'b1000);
    #2;
    rst = 1'b1;
    #1;
    expect_state("rst_mid_run", 16'h0000, 4'b0000);
    #1;
    rst = 1'b0;
    step();
    expect_state("after_rst", 16'h0000, 4'b0000);
    do_load(16'h0010);
    expect_state("load_after_rst", 16'h0010, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_expire();
    test_pause();
    test_load_err();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_timer_down_mm_ss.md
BCD_TIMER_DOWN_MM_SS -- requirements
Module: bcd_timer_down_mm_ss

Interface
REQ-001 Parameter: MIN_TENS_MAX, 5, highest legal minutes-tens digit at load; minutes span 00..(MIN_TENS_MAX*10+9).
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 tick  input  1  one-cycle count enable (1 Hz strobe); decrements by one second when in RUN.
REQ-005 load  input  1  one-cycle request to load preset digits.
REQ-006 start  input  1  one-cycle request to begin or resume counting.
REQ-007 stop  input  1  one-cycle request to pause counting.
REQ-008 pre_min_tens, pre_min_ones, pre_sec_tens, pre_sec_ones  input  4 each  BCD preset digits, sampled when load=1.
REQ-009 min_tens, min_ones, sec_tens, sec_ones  output  4 each  registered BCD count value.
REQ-010 running  output  1  registered; 1 while state is RUN.
REQ-011 expired  output  1  registered level; 1 while state is EXPIRED.
REQ-012 done  output  1  registered one-cycle pulse when count reaches 00:00 from RUN.
REQ-013 load_err  output  1  registered one-cycle pulse on rejected load.

Function
REQ-014 State machine states: IDLE, RUN, PAUSE, EXPIRED; running and expired decode state registers, no combinational glitch paths.
REQ-015 Load validity: ones digits <=9, sec_tens <=5, min_tens <=MIN_TENS_MAX; all four digits checked.
REQ-016 load=1 in IDLE, PAUSE or EXPIRED with valid digits: digits take preset on that edge, state -> IDLE, expired -> 0 on the same edge.
REQ-017 load=1 with any invalid digit: digits and state unchanged, load_err=1 for the next cycle only.
REQ-018 load=1 in RUN: ignored entirely, no load_err.
REQ-019 start=1 in IDLE or PAUSE with count != 00:00: state -> RUN next edge; with count == 00:00: ignored.
REQ-020 start in RUN or EXPIRED: ignored.
REQ-021 stop=1 in RUN: state -> PAUSE, digits unchanged; stop in any other state ignored.
REQ-022 Same-cycle priority: load > stop > start > tick; in RUN, stop and tick together -> PAUSE with no decrement.
REQ-023 Decrement (RUN, tick=1, stop=0): sec_ones 0 -> 9 with borrow, else -1; sec_tens borrow: 0 -> 5 with borrow, else -1; min_ones borrow: 0 -> 9 with borrow, else -1; min_tens borrow: -1.
REQ-024 Decrement latency: new digits visible the cycle after the tick edge; at most one decrement per tick cycle.
REQ-025 Decrement from 00:01: digits -> 00:00, state -> EXPIRED, done=1 on that same edge for exactly one cycle.
REQ-026 Count never wraps below 00:00; EXPIRED holds 00:00 regardless of tick/start/stop; exit only via valid load or rst.
REQ-027 tick outside RUN: no effect; tick held high for N cycles in RUN: N decrements.
REQ-028 done and load_err are 0 in every cycle not specified above.

Reset
REQ-029 rst=1: immediately, without clock, all digits 0, state IDLE, running 0, expired 0, done 0, load_err 0.
REQ-030 rst asserted mid-RUN or on the done cycle: outputs clear asynchronously; no done or load_err pulse follows deassertion.
REQ-031 After rst deassertion, first active edge follows REQ-016..REQ-027 normally.

Verification
REQ-032 Load 01:00, start, one tick -> 00:59, running=1.
REQ-033 Load 10:00, start, one tick -> 09:59 (full borrow chain).
REQ-034 Load 00:02, start, two ticks -> 00:01 then 00:00; done high exactly one cycle; expired=1, running=0; further ticks and start leave 00:00.
REQ-035 Load 03:30, start, stop+tick same cycle -> PAUSE, 03:30 held; start then tick -> 03:29.
REQ-036 Load with pre_sec_tens=6 -> load_err one cycle, digits unchanged; load 00:00 then start -> stays IDLE.
REQ-037 rst pulse during RUN at 05:17 -> 00:00, IDLE, all flags 0 before next clk edge.
